// File: rtl/alu_param.sv
// Multi-cycle ALU with a shift-add multiplier and a small scratch memory.
// One operation in flight at a time; done pulses for one cycle on completion.
module alu_param #(
  parameter int DW    = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [DW-1:0]   A,
  input  logic [DW-1:0]   B,
  input  logic [AW-1:0]   addr,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] result,
  output logic            err
);

  localparam int RW = 2 * DW;
  localparam int CW = $clog2(DW) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] mcand_q, mcand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] result_q, result_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          mem_we;
  logic [RW-1:0] acc_next;
  logic [RW-1:0] mem_q [DEPTH];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    mem_we   = 1'b0;
    acc_next = b_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = A;
          b_d     = B;
          addr_d  = addr;
          acc_d   = '0;
          mcand_d = RW'(A);
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (op == 4'b0100) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          4'b0001: result_d = RW'(a_q) + RW'(b_q);
          4'b0010: result_d = RW'(a_q) & RW'(b_q);
          4'b0011: result_d = RW'(a_q) ^ RW'(b_q);
          4'b0101: result_d = RW'(a_q) + (RW'(b_q) << 1);
          4'b0110: result_d = RW'(a_q) << 1;
          4'b0111: result_d = RW'(a_q) + (RW'(a_q) << 1);
          4'b1000: result_d = mem_q[addr_q];
          4'b1001: mem_we   = 1'b1;
          4'b0000, 4'b0100, 4'b1111: result_d = result_q;
          default: err_d    = 1'b1;
        endcase
      end
      S_MUL: begin
        // b_q shifts right as the multiplier; mcand_q shifts left as the multiplicand.
        acc_d   = acc_next;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          result_d = acc_next;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= result_q;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_param.sv
// Directed-vector bench for alu_param with a done-driven scoreboard monitor.
module tb_alu_param;

  localparam int DW = 8;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic [DW-1:0] A = '0;
  logic [DW-1:0] B = '0;
  logic [AW-1:0] addr = '0;
  logic          busy, done, err;
  logic [RW-1:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit prev_done = 1'b0;

  typedef struct {
    logic [RW-1:0] res;
    logic          e;
    int            due;
  } exp_t;
  exp_t sbq[$];

  alu_param #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
    .addr(addr), .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      total++;
      if (prev_done) begin bad++; $display("FAIL done_twice cyc=%0d", cyc); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%b want=0", busy); end
      total++;
      if (sbq.size() == 0) begin
        bad++; $display("FAIL unexpected_done cyc=%0d result=%h", cyc, result);
      end else begin
        e = sbq.pop_front();
        if (result !== e.res) begin bad++; $display("FAIL result got=%h want=%h", result, e.res); end
        total++;
        if (err !== e.e) begin bad++; $display("FAIL err got=%b want=%b", err, e.e); end
        total++;
        if (cyc != e.due) begin bad++; $display("FAIL latency got=%0d want=%0d", cyc, e.due); end
      end
    end
    prev_done = done;
  end

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL idle_timeout busy=%b want=0", busy);
    end
  endtask

  // Called at a negedge; drives one start pulse and records the expectation.
  task automatic issue(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] ad, input logic [RW-1:0] er, input logic ee,
                       input int lat, input bit push);
    exp_t e;
    wait_idle();
    op = o; A = a; B = b; addr = ad; start = 1'b1;
    if (push) begin
      e.res = er; e.e = ee; e.due = cyc + 1 + lat;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    exp_t e;
    int n;

    repeat (2) @(negedge clk);
    check("rst_result", result, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0000);
    check("rst_done", {15'd0, done}, 16'h0000);
    check("rst_err", {15'd0, err}, 16'h0000);

    // Release reset and request on the same cycle: first edge must accept.
    reset_n = 1'b1;
    issue(4'b0001, 8'hFF, 8'hFF, 5'd0, 16'h01FE, 1'b0, 1, 1'b1);

    issue(4'b0100, 8'hFF, 8'hFF, 5'd0, 16'hFE01, 1'b0, DW, 1'b1);
    for (int j = 1; j < DW; j++) begin
      @(negedge clk);
      check("mul_busy", {15'd0, busy}, 16'h0001);
      check("mul_hold", result, 16'h01FE);
      if (j == 2) begin start = 1'b1; op = 4'b0001; A = 8'h00; B = 8'h00; end
      if (j == 3) start = 1'b0;
    end

    issue(4'b0110, 8'h12, 8'h00, 5'd0, 16'h0024, 1'b0, 1, 1'b1);
    issue(4'b1001, 8'h00, 8'h00, 5'd5, 16'h0024, 1'b0, 1, 1'b1);
    issue(4'b0000, 8'h00, 8'h00, 5'd0, 16'h0024, 1'b0, 1, 1'b1);
    issue(4'b1000, 8'h00, 8'h00, 5'd5, 16'h0024, 1'b0, 1, 1'b1);
    issue(4'b1000, 8'h00, 8'h00, 5'd6, 16'h0000, 1'b0, 1, 1'b1);

    issue(4'b0011, 8'hA5, 8'hFF, 5'd0, 16'h005A, 1'b0, 1, 1'b1);
    issue(4'b0101, 8'h10, 8'h80, 5'd0, 16'h0110, 1'b0, 1, 1'b1);
    issue(4'b0111, 8'hFF, 8'h00, 5'd0, 16'h02FD, 1'b0, 1, 1'b1);
    issue(4'b0100, 8'h0D, 8'h0B, 5'd0, 16'h008F, 1'b0, DW, 1'b1);

    issue(4'b1100, 8'h11, 8'h22, 5'd0, 16'h008F, 1'b1, 1, 1'b1);
    wait_idle();
    @(negedge clk);
    check("err_sticky", {15'd0, err}, 16'h0001);
    issue(4'b0010, 8'hF0, 8'h3C, 5'd0, 16'h0030, 1'b0, 1, 1'b1);

    // Abort a multiply partway through; no done may follow.
    issue(4'b0100, 8'h03, 8'h05, 5'd0, 16'h0000, 1'b0, DW, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {15'd0, busy}, 16'h0000);
    check("abort_result", result, 16'h0000);
    check("abort_done", {15'd0, done}, 16'h0000);
    check("abort_err", {15'd0, err}, 16'h0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    issue(4'b0001, 8'h01, 8'h02, 5'd0, 16'h0003, 1'b0, 1, 1'b1);
    issue(4'b1000, 8'h00, 8'h00, 5'd5, 16'h0000, 1'b0, 1, 1'b1);

    // Start held high: three launches, one every second edge.
    wait_idle();
    op = 4'b0001; A = 8'h01; B = 8'h02; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.res = 16'h0003; e.e = 1'b0; e.due = cyc + 2 + 2 * i;
      sbq.push_back(e);
    end
    repeat (5) @(negedge clk);
    start = 1'b0;

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
